// File: rtl/disp_sched_pkg.sv
// rtl/disp_sched_pkg.sv - shared types and default timing for the display channel scheduler
package disp_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        BLANK = 2'd2
    } sched_state_e;

    localparam int DEFAULT_HOLD_CYCLES  = 25000000;
    localparam int DEFAULT_BLANK_CYCLES = 2500000;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first request at or after ptr_i
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] grant_idx_o,
    output logic          any_req_o
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_req_o   = 1'b0;
        sum         = '0;
        idx         = '0;
        for (int i = 0; i < N; i++) begin
            // ptr < N and i < N, so one subtraction is enough to wrap
            sum = {1'b0, ptr_i} + (PW+1)'(i);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (!any_req_o && req_i[idx]) begin
                any_req_o   = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o = idx;
            end
        end
    end

endmodule

// File: rtl/disp_chan_sched.sv
// rtl/disp_chan_sched.sv - round-robin scheduler sharing a two-digit display among debug channels
// Optional blank gap between grants is enabled by defining DISP_SCHED_BLANK_EN.
module disp_chan_sched
    import disp_sched_pkg::*;
#(
    parameter int NUM_CHAN     = 4,
    parameter int HOLD_CYCLES  = DEFAULT_HOLD_CYCLES,
    parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst,
    input  logic [NUM_CHAN-1:0]         i_Req,
    input  logic [8*NUM_CHAN-1:0]       i_Data,
    output logic [NUM_CHAN-1:0]         o_Ack,
    output logic [3:0]                  o_Hi_Nibble,
    output logic [3:0]                  o_Lo_Nibble,
    output logic [$clog2(NUM_CHAN)-1:0] o_Chan,
    output logic                        o_Busy,
    output logic                        o_Blank
);

    localparam int PW    = $clog2(NUM_CHAN);
    localparam int CNT_W = $clog2(HOLD_CYCLES);

    sched_state_e          state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [PW-1:0]         rr_ptr_q;
    logic [NUM_CHAN-1:0]   ack_q;
    logic [7:0]            byte_q;
    logic [PW-1:0]         chan_q;
    logic                  busy_q;

    logic [NUM_CHAN-1:0]   grant;
    logic [PW-1:0]         grant_idx;
    logic                  any_req;
    logic [7:0]            sel_byte;
    logic [PW-1:0]         rr_ptr_d;
    logic                  arb_pt;

    rr_arbiter #(
        .N  (NUM_CHAN),
        .PW (PW)
    ) u_arb (
        .req_i       (i_Req),
        .ptr_i       (rr_ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_req_o   (any_req)
    );

    always_comb begin
        sel_byte = '0;
        for (int k = 0; k < NUM_CHAN; k++) begin
            if (grant[k]) begin
                sel_byte = i_Data[8*k +: 8];
            end
        end
    end

    assign rr_ptr_d = (grant_idx == PW'(NUM_CHAN - 1)) ? '0 : grant_idx + 1'b1;

`ifdef DISP_SCHED_BLANK_EN
    localparam int BCNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    logic [BCNT_W-1:0] bcnt_q;
    logic              blank_q;

    always_comb begin
        arb_pt = 1'b0;
        case (state_q)
            IDLE:    arb_pt = 1'b1;
            BLANK:   arb_pt = (bcnt_q == '0);
            default: arb_pt = 1'b0;
        endcase
    end
`else
    always_comb begin
        arb_pt = 1'b0;
        case (state_q)
            IDLE:    arb_pt = 1'b1;
            HOLD:    arb_pt = (cnt_q == '0);
            default: arb_pt = 1'b0;
        endcase
    end
`endif

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            ack_q    <= '0;
            byte_q   <= '0;
            chan_q   <= '0;
            busy_q   <= 1'b0;
`ifdef DISP_SCHED_BLANK_EN
            bcnt_q   <= '0;
            blank_q  <= 1'b0;
`endif
        end else begin
            ack_q <= '0;
            if (arb_pt && any_req) begin
                state_q  <= HOLD;
                cnt_q    <= CNT_W'(HOLD_CYCLES - 1);
                ack_q    <= grant;
                byte_q   <= sel_byte;
                chan_q   <= grant_idx;
                busy_q   <= 1'b1;
                rr_ptr_q <= rr_ptr_d;
`ifdef DISP_SCHED_BLANK_EN
                blank_q  <= 1'b0;
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        busy_q <= 1'b0;
                    end
                    HOLD: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else begin
                            busy_q <= 1'b0;
`ifdef DISP_SCHED_BLANK_EN
                            state_q <= BLANK;
                            bcnt_q  <= BCNT_W'(BLANK_CYCLES - 1);
                            blank_q <= 1'b1;
`else
                            state_q <= IDLE;
`endif
                        end
                    end
`ifdef DISP_SCHED_BLANK_EN
                    BLANK: begin
                        if (bcnt_q != '0) begin
                            bcnt_q <= bcnt_q - 1'b1;
                        end else begin
                            state_q <= IDLE;
                            blank_q <= 1'b0;
                        end
                    end
`endif
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_Ack       = ack_q;
    assign o_Hi_Nibble = byte_q[7:4];
    assign o_Lo_Nibble = byte_q[3:0];
    assign o_Chan      = chan_q;
    assign o_Busy      = busy_q;
`ifdef DISP_SCHED_BLANK_EN
    assign o_Blank     = blank_q;
`else
    assign o_Blank     = 1'b0;
`endif

endmodule

// File: tb/tb_disp_chan_sched.sv
// tb/tb_disp_chan_sched.sv - scoreboard bench for disp_chan_sched (NUM_CHAN=4, HOLD=4, BLANK=2)
module tb_disp_chan_sched;

`ifdef DISP_SCHED_BLANK_EN
    localparam int HG = 2;
`else
    localparam int HG = 0;
`endif

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  ack;
    logic [3:0]  hi;
    logic [3:0]  lo;
    logic [1:0]  chan;
    logic        busy;
    logic        blank;

    typedef struct {
        logic [3:0] ack;
        logic [3:0] hi;
        logic [3:0] lo;
        logic [1:0] chan;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    disp_chan_sched #(
        .NUM_CHAN     (4),
        .HOLD_CYCLES  (4),
        .BLANK_CYCLES (2)
    ) dut (
        .i_Clk       (clk),
        .i_Rst       (rst),
        .i_Req       (req),
        .i_Data      (data),
        .o_Ack       (ack),
        .o_Hi_Nibble (hi),
        .o_Lo_Nibble (lo),
        .o_Chan      (chan),
        .o_Busy      (busy),
        .o_Blank     (blank)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, got, want, cyc);
        end
    endtask

    task automatic expect_ack(input int ch, input logic [7:0] b, input int at);
        exp_t e;
        e.ack  = 4'b0001 << ch;
        e.hi   = b[7:4];
        e.lo   = b[3:0];
        e.chan = 2'(ch);
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Monitor: every ack pulse pops the next expected grant
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        #1;
        if (ack !== 4'b0000) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack: got ack=%b with none expected (cyc %0d)", ack, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("ack_vec",  32'(ack),  32'(e.ack));
                chk("ack_hi",   32'(hi),   32'(e.hi));
                chk("ack_lo",   32'(lo),   32'(e.lo));
                chk("ack_chan", 32'(chan), 32'(e.chan));
                chk("ack_cyc",  32'(cyc),  32'(e.cyc));
                chk("ack_busy", 32'(busy), 32'd1);
            end
        end
    end

    initial begin
        int c;
        req  = '0;
        data = '0;
        rst  = 1'b0;
        #2 rst = 1'b1;
        step();
        chk("rst_ack",   32'(ack),   32'd0);
        chk("rst_hi",    32'(hi),    32'd0);
        chk("rst_lo",    32'(lo),    32'd0);
        chk("rst_chan",  32'(chan),  32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_blank", 32'(blank), 32'd0);
        step();
        rst = 1'b0;
        step();

        // Single grant to channel 2 with byte A5
        data = 32'h3C_A5_96_11;
        req  = 4'b0100;
        c = cyc;
        expect_ack(2, 8'hA5, c + 1);
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 1) req = 4'b0000;
            chk("t1_busy",  32'(busy),  (k <= 4) ? 32'd1 : 32'd0);
            chk("t1_blank", 32'(blank), (k == 5 && HG != 0) ? 32'd1 : 32'd0);
        end
        repeat (8) step();

        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

`ifdef DISP_SCHED_BLANK_EN
        // Two requesters with a blank gap between holds
        data = 32'h4B_3C_2D_1E;
        req  = 4'b0011;
        c = cyc;
        expect_ack(0, 8'h1E, c + 1);
        expect_ack(1, 8'h2D, c + 7);
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 1) req = 4'b0010;
            if (k == 7) req = 4'b0000;
            chk("blk_blank", 32'(blank), (k == 5 || k == 6) ? 32'd1 : 32'd0);
            chk("blk_busy",  32'(busy),  (k == 5 || k == 6) ? 32'd0 : 32'd1);
        end
        repeat (12) step();
`else
        // All four requesting: back-to-back rotation 0,1,2,3,0
        data = 32'h4B_3C_2D_1E;
        req  = 4'b1111;
        c = cyc;
        expect_ack(0, 8'h1E, c + 1);
        expect_ack(1, 8'h2D, c + 5);
        expect_ack(2, 8'h3C, c + 9);
        expect_ack(3, 8'h4B, c + 13);
        expect_ack(0, 8'h1E, c + 17);
        for (int k = 1; k <= 17; k++) begin
            step();
            chk("rr_busy", 32'(busy), 32'd1);
        end
        req = 4'b0000;
        repeat (8) step();
        chk("rr_idle_busy", 32'(busy), 32'd0);
`endif

        // Channel 0 arrives mid-hold of channel 3; granted right after the hold
        data = 32'h4B_3C_2D_58;
        req  = 4'b1000;
        c = cyc;
        expect_ack(3, 8'h4B, c + 1);
        expect_ack(0, 8'h58, c + 5 + HG);
        step();
        req = 4'b0000;
        step();
        req = 4'b0001;
        repeat (3 + HG) step();
        req = 4'b0000;
        repeat (10) step();

        // Channel 1 withdraws before its grant while channel 0 holds
        data = 32'h4B_3C_2D_7F;
        req  = 4'b0001;
        c = cyc;
        expect_ack(0, 8'h7F, c + 1);
        step();
        req = 4'b0000;
        step();
        req = 4'b0010;
        step();
        req = 4'b0000;
        repeat (3 + HG) step();
        chk("wd_busy", 32'(busy), 32'd0);
        chk("wd_chan", 32'(chan), 32'd0);
        chk("wd_hi",   32'(hi),   32'h7);
        chk("wd_lo",   32'(lo),   32'hF);
        repeat (4) step();

        // Asynchronous reset during hold cycle 2 of channel 1
        data = 32'hC3_3C_96_7F;
        req  = 4'b0010;
        c = cyc;
        expect_ack(1, 8'h96, c + 1);
        step();
        req = 4'b0000;
        step();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_hi",   32'(hi),   32'd0);
        chk("arst_lo",   32'(lo),   32'd0);
        chk("arst_chan", 32'(chan), 32'd0);
        chk("arst_ack",  32'(ack),  32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        req = 4'b1010;
        c = cyc;
        expect_ack(1, 8'h96, c + 1);
        step();
        req = 4'b0000;
        repeat (12) step();

        chk("pending_acks", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
